// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared defaults and tag types for the instruction-memory arbiter
package imem_pkg;

    localparam int NUM_CORES_DEF = 4;
    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int CORE_ID_W     = $clog2(NUM_CORES_DEF);

    typedef logic [CORE_ID_W-1:0] core_id_t;

    typedef struct packed {
        logic     valid;
        core_id_t id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot pick with rotating priority pointer
module rr_arbiter
    import imem_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    output logic [NUM_CORES-1:0] gnt,
    output core_id_t             win_id
);

    core_id_t rr_ptr;
    logic     found;
    int       idx;
    core_id_t cid;

    // scan upward from rr_ptr, wrapping, and take the first requester
    always_comb begin
        gnt    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        cid    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            cid = core_id_t'(idx);
            if (!found && req[cid]) begin
                found    = 1'b1;
                gnt[cid] = 1'b1;
                win_id   = cid;
            end
        end
    end

    // after a grant the core just served drops to lowest priority
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (found) begin
            if (win_id == core_id_t'(NUM_CORES - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= win_id + core_id_t'(1);
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - shares one instruction-memory read port among core fetch stages
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int NUM_CORES   = NUM_CORES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES-1:0]        flush,
    output logic [NUM_CORES-1:0]        gnt,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [NUM_CORES-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_ins
);

    logic [NUM_CORES-1:0] eligible;
    core_id_t             win_id;
    tag_t                 pipe [MEM_LATENCY];
    tag_t                 tail;

    // a flushing core cannot win, and nothing is granted while in reset
    assign eligible = req & ~flush & {NUM_CORES{~rst}};

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (eligible),
        .gnt    (gnt),
        .win_id (win_id)
    );

    assign mem_en = |gnt;

    // route the winner's PC to memory; address is zero when idle
    always_comb begin
        mem_addr = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (gnt[k]) begin
                mem_addr = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // tag shift register follows each read through the memory latency;
    // a flush kills that core's entries as they advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= mem_en;
            pipe[0].id    <= win_id;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe[i].valid <= pipe[i-1].valid & ~flush[pipe[i-1].id];
                pipe[i].id    <= pipe[i-1].id;
            end
        end
    end

    assign tail = pipe[MEM_LATENCY-1];

    // steer the returning instruction to its core unless that core is flushing now
    always_comb begin
        rsp_valid = '0;
        rsp_ins   = '0;
        if (!rst && tail.valid && !flush[tail.id]) begin
            rsp_valid[tail.id] = 1'b1;
            rsp_ins            = mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed vector bench for imem_arbiter at latencies 1, 2 and 3
module tb_imem_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [3:0]   flush;
    logic [31:0]  mem_rdata;

    logic [3:0]   gnt1, gnt2, gnt3;
    logic         en1, en2, en3;
    logic [31:0]  addr1, addr2, addr3;
    logic [3:0]   rv1, rv2, rv3;
    logic [31:0]  ins1, ins2, ins3;

    int n_chk;
    int n_fail;

    imem_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .flush(flush),
        .gnt(gnt1), .mem_en(en1), .mem_addr(addr1), .mem_rdata(mem_rdata),
        .rsp_valid(rv1), .rsp_ins(ins1)
    );

    imem_arbiter #(.MEM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .flush(flush),
        .gnt(gnt2), .mem_en(en2), .mem_addr(addr2), .mem_rdata(mem_rdata),
        .rsp_valid(rv2), .rsp_ins(ins2)
    );

    imem_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .flush(flush),
        .gnt(gnt3), .mem_en(en3), .mem_addr(addr3), .mem_rdata(mem_rdata),
        .rsp_valid(rv3), .rsp_ins(ins3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  flush;
        logic [31:0] rdata;
        logic [3:0]  gnt;
        logic [31:0] addr;
        logic [3:0]  rv;
        logic [31:0] ins;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] f, input logic [31:0] d);
        rst       = r;
        req       = q;
        flush     = f;
        mem_rdata = d;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        req_addr = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};

        //             rst   req      flush    rdata          gnt      addr           rv       ins
        vecs[0]  = '{1'b0, 4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 32'h0000_0100, 4'b0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 32'h0050_0093, 4'b0000, 32'h0000_0000, 4'b0001, 32'h0050_0093};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 32'hDEAD_0000, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0000, 4'b0001, 32'h0000_0100, 4'b0000, 32'h0000_0000};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0001, 4'b0010, 32'h0000_0200, 4'b0001, 32'hA000_0001};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0002, 4'b0100, 32'h0000_0300, 4'b0010, 32'hA000_0002};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0003, 4'b1000, 32'h0000_0400, 4'b0100, 32'hA000_0003};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0004, 4'b0001, 32'h0000_0100, 4'b1000, 32'hA000_0004};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0005, 4'b0010, 32'h0000_0200, 4'b0001, 32'hA000_0005};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0006, 4'b0100, 32'h0000_0300, 4'b0010, 32'hA000_0006};
        vecs[10] = '{1'b0, 4'b1111, 4'b0000, 32'hA000_0007, 4'b1000, 32'h0000_0400, 4'b0100, 32'hA000_0007};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 32'hB000_0000, 4'b0000, 32'h0000_0000, 4'b1000, 32'hB000_0000};
        vecs[12] = '{1'b0, 4'b0100, 4'b0000, 32'hB000_0001, 4'b0100, 32'h0000_0300, 4'b0000, 32'h0000_0000};
        vecs[13] = '{1'b0, 4'b1001, 4'b0000, 32'hB000_0002, 4'b1000, 32'h0000_0400, 4'b0100, 32'hB000_0002};
        vecs[14] = '{1'b0, 4'b1001, 4'b0000, 32'hB000_0003, 4'b0001, 32'h0000_0100, 4'b1000, 32'hB000_0003};
        vecs[15] = '{1'b0, 4'b0100, 4'b0100, 32'hB000_0004, 4'b0000, 32'h0000_0000, 4'b0001, 32'hB000_0004};
        vecs[16] = '{1'b0, 4'b1111, 4'b0000, 32'hB000_0005, 4'b0010, 32'h0000_0200, 4'b0000, 32'h0000_0000};
        vecs[17] = '{1'b0, 4'b0000, 4'b0010, 32'hB000_0006, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[18] = '{1'b0, 4'b0010, 4'b0000, 32'hB000_0007, 4'b0010, 32'h0000_0200, 4'b0000, 32'h0000_0000};
        vecs[19] = '{1'b0, 4'b0010, 4'b0000, 32'hB000_0008, 4'b0010, 32'h0000_0200, 4'b0010, 32'hB000_0008};
        vecs[20] = '{1'b0, 4'b0000, 4'b0000, 32'hB000_0009, 4'b0000, 32'h0000_0000, 4'b0010, 32'hB000_0009};

        // reset, with requests pending to show they are ignored
        drive(1'b1, 4'b1111, 4'b0000, 32'h1234_5678);
        tick();
        tick();
        @(negedge clk);
        chk("rst_gnt", {28'h0, gnt1}, 32'h0);
        chk("rst_mem_en", {31'h0, en1}, 32'h0);
        chk("rst_mem_addr", addr1, 32'h0);
        chk("rst_rsp_valid", {28'h0, rv1}, 32'h0);
        chk("rst_rsp_ins", ins1, 32'h0);
        tick();

        // latency-1 table
        for (int v = 0; v < 21; v++) begin
            drive(vecs[v].rst, vecs[v].req, vecs[v].flush, vecs[v].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", v), {28'h0, gnt1}, {28'h0, vecs[v].gnt});
            chk($sformatf("v%0d_mem_en", v), {31'h0, en1}, {31'h0, (vecs[v].gnt != 4'b0000)});
            chk($sformatf("v%0d_mem_addr", v), addr1, vecs[v].addr);
            chk($sformatf("v%0d_rsp_valid", v), {28'h0, rv1}, {28'h0, vecs[v].rv});
            chk($sformatf("v%0d_rsp_ins", v), ins1, vecs[v].ins);
            tick();
        end

        // latency 3: flush of core 2 while its read is in flight, core 1 unaffected
        drive(1'b1, 4'b0000, 4'b0000, 32'h0);
        tick();
        drive(1'b0, 4'b0100, 4'b0000, 32'hC000_0000);
        @(negedge clk);
        chk("l3_T_gnt", {28'h0, gnt3}, 32'h4);
        tick();
        drive(1'b0, 4'b0010, 4'b0100, 32'hC000_0001);
        @(negedge clk);
        chk("l3_T1_gnt", {28'h0, gnt3}, 32'h2);
        chk("l3_T1_rsp_valid", {28'h0, rv3}, 32'h0);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 32'hC000_0002);
        @(negedge clk);
        chk("l3_T2_rsp_valid", {28'h0, rv3}, 32'h0);
        tick();
        mem_rdata = 32'hC000_0003;
        @(negedge clk);
        chk("l3_T3_rsp_valid", {28'h0, rv3}, 32'h0);
        chk("l3_T3_rsp_ins", ins3, 32'h0);
        tick();
        mem_rdata = 32'hC000_0004;
        @(negedge clk);
        chk("l3_T4_rsp_valid", {28'h0, rv3}, 32'h2);
        chk("l3_T4_rsp_ins", ins3, 32'hC000_0004);
        tick();
        @(negedge clk);
        chk("l3_T5_rsp_valid", {28'h0, rv3}, 32'h0);
        tick();

        // latency 2: reset in the cycle after a grant drops the read and the pointer
        drive(1'b1, 4'b0000, 4'b0000, 32'h0);
        tick();
        drive(1'b0, 4'b0001, 4'b0000, 32'hD000_0000);
        @(negedge clk);
        chk("l2_T_gnt", {28'h0, gnt2}, 32'h1);
        tick();
        drive(1'b1, 4'b0010, 4'b0000, 32'hD000_0001);
        @(negedge clk);
        chk("l2_T1_gnt", {28'h0, gnt2}, 32'h0);
        chk("l2_T1_mem_en", {31'h0, en2}, 32'h0);
        tick();
        for (int c = 2; c <= 4; c++) begin
            drive(1'b0, 4'b0000, 4'b0000, 32'hD000_0000 + 32'(c));
            @(negedge clk);
            chk($sformatf("l2_T%0d_rsp_valid", c), {28'h0, rv2}, 32'h0);
            chk($sformatf("l2_T%0d_rsp_ins", c), ins2, 32'h0);
            tick();
        end
        drive(1'b0, 4'b1111, 4'b0000, 32'hD000_0005);
        @(negedge clk);
        chk("l2_ptr_after_rst", {28'h0, gnt2}, 32'h1);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction-memory read port between the fetch stages of `NUM_CORES` cores in the multicore RISC-V design. Each core's fetch stage raises a request with its PC. The block grants one core per cycle using round-robin priority and drives the memory address. It then returns the fetched instruction to the granted core after the fixed memory latency. A per-core flush discards in-flight responses on redirect (branch/jump/reset of a core).

## Interface
- `NUM_CORES`, default 4: number of requesting fetch stages (≥2).
- `ADDR_W`, default 32: PC/address width.
- `DATA_W`, default 32: instruction width.
- `MEM_LATENCY`, default 1: cycles from `mem_en` to valid `mem_rdata` (≥1, fixed).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req` in `NUM_CORES`: per-core fetch request.
- `req_addr` in `NUM_CORES*ADDR_W`: per-core PC. Core i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `flush` in `NUM_CORES`: per-core kill of pending responses.
- `gnt` out `NUM_CORES`: one-hot grant, combinational, same cycle as the request.
- `mem_en` out 1: memory read strobe.
- `mem_addr` out `ADDR_W`: address of the granted core.
- `mem_rdata` in `DATA_W`: memory read data.
- `rsp_valid` out `NUM_CORES`: one-hot, instruction valid for core i.
- `rsp_ins` out `DATA_W`: returned instruction, shared by all cores, qualified by `rsp_valid`.

## Operation
- Eligible set is `req & ~flush`. If it is empty: `gnt=0`, `mem_en=0`.
- Otherwise the winner is the first eligible core starting at pointer `rr_ptr`, scanning upward and wrapping from `NUM_CORES-1` to 0.
- For the winner: `gnt[k]=1`, `mem_en=1`, `mem_addr=req_addr[k]`.
- When `mem_en=0`, `mem_addr` is 0.
- `rr_ptr` updates at the clock edge:
  - after a grant to k, `rr_ptr` becomes `(k+1) mod NUM_CORES`;
  - with no grant, `rr_ptr` is unchanged.
- Requester protocol:
  - a requester holds `req` and `req_addr` stable until it sees `gnt`;
  - a core with `req` held high continuously is granted at most every `NUM_CORES` cycles under full contention;
  - a core may re-request in the cycle after its grant.
- Tag pipeline: a shift register `MEM_LATENCY` deep. Each entry is {valid, core_id}. Each cycle it loads {`mem_en`, winner id}.
- When the tail entry is valid for core j and `flush[j]=0`: `rsp_valid[j]=1`, `rsp_ins=mem_rdata`.
- If the tail entry is invalid, `rsp_valid=0` and `rsp_ins=0`.
- Flush:
  - `flush[j]` in cycle C clears the valid bit of every in-flight entry tagged j at the edge ending C;
  - it also suppresses `rsp_valid[j]` in C;
  - it blocks a grant to j in C;
  - entries belonging to other cores are untouched.

## Timing
- Reset values: `rr_ptr=0` (core 0 has top priority), all tag entries invalid. While `rst=1`: `gnt=0`, `mem_en=0`, `mem_addr=0`, `rsp_valid=0`, `rsp_ins=0`.
- Grant latency is 0 cycles: request in cycle T gives `gnt` and `mem_en` in T.
- Response latency: `rsp_valid` is asserted in cycle T+`MEM_LATENCY`.
- Throughput is one grant per cycle. There is no backpressure on responses; cores always accept `rsp_valid`.
- Reset mid-operation: all in-flight responses are dropped. No `rsp_valid` appears in the cycles after `rst` deasserts until new grants mature.
- Boundary cases:
  - grant and flush of the same core in the same cycle: flush wins, no grant;
  - a response arriving in the same cycle as a new grant to the same core: both occur, since they are independent;
  - `rr_ptr` wrap from `NUM_CORES-1` to 0 is tested.

## Structure
- Shared package `imem_pkg` holds:
  - `NUM_CORES`, `ADDR_W`, `DATA_W` defaults;
  - `core_id_t`, `$clog2(NUM_CORES)` bits wide;
  - `tag_t` = {valid, `core_id_t`}.
- Sub-module `rr_arbiter` holds the round-robin pick (req vector in, one-hot gnt plus winner id out) and the `rr_ptr` register.
- The top level holds the address mux, the tag shift register and the response demux.

## Test plan
- Reset, then `req=4'b0001`, `req_addr[0]=0x100`: `gnt=0001`, `mem_addr=0x100` same cycle. With `MEM_LATENCY=1` and `mem_rdata=0x00500093`, the next cycle gives `rsp_valid=0001`, `rsp_ins=0x00500093`.
- `req=4'b1111` held for 8 cycles from reset: grant order 0,1,2,3,0,1,2,3. Each response goes to the matching core one cycle later.
- `rr_ptr=3`, `req=4'b1001`: core 3 is granted. With `req` held, the next cycle grants core 0, confirming wrap.
- `MEM_LATENCY=3`: grant core 2 at T. Pulse `flush[2]` at T+1 while core 1 is granted at T+1. Required: no `rsp_valid[2]`; `rsp_valid[1]` at T+4.
- `req=4'b0100` and `flush=4'b0100` in the same cycle: `gnt=0`, `mem_en=0`, `rr_ptr` unchanged.
- Grants at T and T+1, then `rst` pulsed at T+1 (`MEM_LATENCY=2`): `rsp_valid` stays 0 through T+4, and `rr_ptr` returns to 0.
